// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer:
// default word width, bit-count width helper and output-buffer state.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  // Counter must hold 0..w-1; a 2-bit word still needs one count bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input and parallel output bundle of the deserializer, plus the
// output-buffer state for observation.
interface sipo_deser_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // Handshakes: a serial bit is consumed on every rising edge where
  // sin_valid=1 (no backpressure on the input side). A parallel word moves
  // downstream on every rising edge where q_valid=1 and q_ready=1; q_valid
  // never drops and q never changes while q_valid=1 and q_ready=0.
  logic             sin;
  logic             sin_valid;
  logic             flush;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             busy;
  logic             overrun;
  logic             clr_ovr;
  buf_state_t       state;

  modport master (
    output sin, sin_valid, flush, q_ready, clr_ovr,
    input  q, q_valid, busy, overrun, state
  );

  modport slave (
    input  sin, sin_valid, flush, q_ready, clr_ovr,
    output q, q_valid, busy, overrun, state
  );

endinterface

// File: rtl/sipo_shift_stage.sv
// Shift register and bit counter. Flags the edge on which a word completes
// and presents the completed word combinationally for the output buffer.
module sipo_shift_stage
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CW-1:0]    count;
  logic             last;

  always_comb begin
    shreg_next = shreg;
    if (MSB_FIRST) shreg_next = {shreg[WIDTH-2:0], sin};
    else           shreg_next = {sin, shreg[WIDTH-1:1]};
  end

  assign last = (count == CW'(WIDTH - 1));
  assign done = sin_valid & ~flush & last;
  assign word = shreg_next;
  assign busy = (count != '0);

  // flush outranks a bit sampled on the same edge: that bit is discarded.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      shreg <= '0;
      count <= '0;
    end else if (flush) begin
      shreg <= '0;
      count <= '0;
    end else if (sin_valid) begin
      shreg <= shreg_next;
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: shift stage feeding a one-word
// output buffer with valid/ready handshake and a sticky overrun flag.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         clear,
  sipo_deser_if.slave  bus
);

  logic [WIDTH-1:0] word;
  logic             done;
  logic             busy_w;
  logic [WIDTH-1:0] q_r;
  logic             overrun_r;
  buf_state_t       state;
  logic             transfer;
  logic             drop;

  sipo_shift_stage #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .clear     (clear),
    .sin       (bus.sin),
    .sin_valid (bus.sin_valid),
    .flush     (bus.flush),
    .word      (word),
    .done      (done),
    .busy      (busy_w)
  );

  assign transfer = (state == FULL) & bus.q_ready;
  assign drop     = (state == FULL) & done & ~bus.q_ready;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= EMPTY;
      q_r       <= '0;
      overrun_r <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (done) begin
            q_r   <= word;
            state <= FULL;
          end
        end
        FULL: begin
          // A word completing on the transfer edge refills the buffer directly.
          if (transfer && done) q_r   <= word;
          else if (transfer)    state <= EMPTY;
        end
      endcase
      if (drop)             overrun_r <= 1'b1;
      else if (bus.clr_ovr) overrun_r <= 1'b0;
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = (state == FULL);
  assign bus.busy    = busy_w;
  assign bus.overrun = overrun_r;
  assign bus.state   = state;

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4: word width in bits; legal range >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in q[WIDTH-1]; 0 = first bit lands in q[0].
REQ-003 One clock; reset is asynchronous and active-high. Port clk, input, 1: rising-edge clock.
REQ-004 Port clear, input, 1: asynchronous active-high reset.
REQ-005 Port sin, input, 1: serial data bit.
REQ-006 Port sin_valid, input, 1: sin is sampled on this edge.
REQ-007 Port flush, input, 1: synchronous discard of a partially assembled word.
REQ-008 Port q, output, WIDTH: assembled parallel word (output register).
REQ-009 Port q_valid, output, 1: q holds an unconsumed word.
REQ-010 Port q_ready, input, 1: downstream accepts q this cycle; transfer = q_valid & q_ready.
REQ-011 Port busy, output, 1: partial word in progress (bit count != 0).
REQ-012 Port overrun, output, 1: sticky flag; a completed word was dropped.
REQ-013 Port clr_ovr, input, 1: synchronous clear of overrun.

Function
REQ-014 Bit capture: on a clk edge with sin_valid=1 and flush=0, the block shifts sin into the shift register and increments the bit count.
- MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin}.
- MSB_FIRST=0: shreg <= {sin, shreg[WIDTH-1:1]}.
REQ-015 Cycles with sin_valid=0 leave the shift register and the bit count unchanged; gaps of any length are legal.
REQ-016 Completion: a sampled bit arriving with count = WIDTH-1 completes a word. The completed word includes that bit, and the count wraps to 0 on the same edge.
REQ-017 The output buffer has two states, EMPTY (q_valid=0) and FULL (q_valid=1).
- EMPTY + completion -> FULL; q loads the word on that edge, so q_valid is high on the cycle after the last bit is sampled (latency 1).
- FULL + transfer, no completion -> EMPTY; q keeps its last value.
- FULL + transfer + completion on the same edge -> stays FULL with the new word; overrun is not set.
- FULL + completion, no transfer -> stays FULL, q unchanged, new word dropped, overrun set to 1.
REQ-018 While FULL without a transfer, q and q_valid shall remain stable.
REQ-019 overrun shall stay high until clr_ovr=1. If clr_ovr and a new overrun occur on the same edge, set wins.
REQ-020 flush=1 clears the bit count and the shift register on the next edge, and any sin bit sampled that cycle is discarded. flush shall not affect q, q_valid or overrun.
REQ-021 busy = (count != 0), driven from registers.
REQ-022 The bit count width is clog2(WIDTH); it shall never exceed WIDTH-1.

Reset
REQ-023 clear=1 forces, asynchronously: q=0, q_valid=0, overrun=0, busy=0, count=0, shreg=0.
REQ-024 clear asserted mid-word discards the partial word. The first sampled bit after clear deasserts is bit 0 of a new word.

Structure
REQ-025 A shared package sipo_pkg shall hold the WIDTH default, the count-width function (clog2) and the output-buffer state enum {EMPTY, FULL}.
REQ-026 One sub-module, sipo_shift_stage, shall contain the shift register and bit counter and produce word/done outputs. The top level shall contain the output buffer, handshake logic and overrun logic.

Verification
REQ-027 WIDTH=4, MSB_FIRST=1, q_ready=1; send sin 1,0,1,1 on consecutive edges -> q=4'b1011, q_valid=1 for exactly one cycle, starting the cycle after the 4th bit.
REQ-028 MSB_FIRST=0, same bits -> q=4'b1101.
REQ-029 q_ready=0; send 1,0,1,0 then 0,1,1,0 -> q holds 4'b1010, overrun=1 after the 8th bit; pulse clr_ovr -> overrun=0 while q is still 4'b1010.
REQ-030 Hold q_ready=1 while a second word 0,1,1,0 completes on the same edge as the first word's transfer -> q=4'b0110, q_valid stays 1, overrun=0.
REQ-031 Send 1,1 then flush, then 0,0,0,1 -> busy drops after flush, q=4'b0001; toggle sin_valid with random gaps -> same result.
REQ-032 Assert clear after 3 bits, release, send 1,1,1,1 -> all outputs 0 during clear, then q=4'b1111.
